// File: rtl/boruss_rom_arbiter.sv
// Two-port round-robin arbiter in front of a combinational ROM: CPU fetch and debug monitor,
// each read taking IDLE -> READ -> ACK, with an optional debug lock that locks out the CPU.
module boruss_rom_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic              dbg_req,
    input  logic [ADDR_W-1:0] dbg_addr,
    input  logic              dbg_lock,
    output logic [ADDR_W-1:0] rom_address,
    input  logic [DATA_W-1:0] rom_data,
    output logic              cpu_ack,
    output logic              dbg_ack,
    output logic [DATA_W-1:0] rd_data,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, READ, ACK} state_t;

    state_t            state;
    logic [ADDR_W-1:0] addr_q;
    logic              last_grant;  // 1 = debug port was granted last
    logic              owner;       // 1 = debug port owns the current read
    logic              cpu_elig;
    logic              dbg_elig;
    logic              pick_dbg;

    // Debug wins when the CPU is not eligible, or on a tie when the CPU was served last.
    always_comb begin
        cpu_elig = cpu_req & ~dbg_lock;
        dbg_elig = dbg_req;
        pick_dbg = dbg_elig & (~cpu_elig | ~last_grant);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            rom_address <= '0;
            addr_q      <= '0;
            rd_data     <= '0;
            cpu_ack     <= 1'b0;
            dbg_ack     <= 1'b0;
            busy        <= 1'b0;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    if (cpu_elig || dbg_elig) begin
                        owner       <= pick_dbg;
                        last_grant  <= pick_dbg;
                        addr_q      <= pick_dbg ? dbg_addr : cpu_addr;
                        rom_address <= pick_dbg ? dbg_addr : cpu_addr;
                        state       <= READ;
                        busy        <= 1'b1;
                    end
                end
                READ: begin
                    rd_data <= rom_data;
                    cpu_ack <= ~owner;
                    dbg_ack <= owner;
                    state   <= ACK;
                    busy    <= 1'b1;
                end
                ACK: begin
                    // Requests are not sampled here, so a held req only re-arbitrates from IDLE.
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
                default: begin
                    cpu_ack <= 1'b0;
                    dbg_ack <= 1'b0;
                    state   <= IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_boruss_rom_arbiter.sv
// Directed bench for boruss_rom_arbiter with a behavioural combinational ROM.
module tb_boruss_rom_arbiter;

    logic       clk = 1'b0;
    logic       rst;
    logic       cpu_req;
    logic [7:0] cpu_addr;
    logic       dbg_req;
    logic [7:0] dbg_addr;
    logic       dbg_lock;
    logic [7:0] rom_address;
    logic [7:0] rom_data;
    logic       cpu_ack;
    logic       dbg_ack;
    logic [7:0] rd_data;
    logic       busy;

    logic [7:0] rom [256];
    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    assign rom_data = rom[rom_address];

    boruss_rom_arbiter #(.ADDR_W(8), .DATA_W(8)) dut (
        .clk(clk), .rst(rst),
        .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .dbg_req(dbg_req), .dbg_addr(dbg_addr), .dbg_lock(dbg_lock),
        .rom_address(rom_address), .rom_data(rom_data),
        .cpu_ack(cpu_ack), .dbg_ack(dbg_ack), .rd_data(rd_data), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_out();
        cpu_req  = 1'b0;
        dbg_req  = 1'b0;
        dbg_lock = 1'b0;
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else passed++;
        total++; if ({cpu_ack, dbg_ack} !== 2'b00) $display("FAIL reset_acks: got %b expected 00", {cpu_ack, dbg_ack}); else passed++;
        total++; if (rd_data !== 8'h00) $display("FAIL reset_rd_data: got %h expected 00", rd_data); else passed++;
        total++; if (rom_address !== 8'h00) $display("FAIL reset_rom_address: got %h expected 00", rom_address); else passed++;
        rst = 1'b0;
    endtask

    task automatic test_single();
        cpu_addr = 8'h02;
        cpu_req  = 1'b1;
        tick();
        total++; if (rom_address !== 8'h02) $display("FAIL single_rom_address: got %h expected 02", rom_address); else passed++;
        total++; if (busy !== 1'b1 || cpu_ack !== 1'b0) $display("FAIL single_read_state: got busy=%b ack=%b expected busy=1 ack=0", busy, cpu_ack); else passed++;
        tick();
        total++; if (cpu_ack !== 1'b1 || dbg_ack !== 1'b0) $display("FAIL single_ack: got cpu=%b dbg=%b expected cpu=1 dbg=0", cpu_ack, dbg_ack); else passed++;
        total++; if (rd_data !== 8'h60) $display("FAIL single_rd_data: got %h expected 60", rd_data); else passed++;
        tick();
        total++; if (cpu_ack !== 1'b0 || busy !== 1'b0) $display("FAIL single_ack_end: got ack=%b busy=%b expected 0 0", cpu_ack, busy); else passed++;
        cpu_req = 1'b0;
        tick();
        total++; if (busy !== 1'b0) $display("FAIL single_no_rereq: got busy=%b expected 0", busy); else passed++;
        total++; if (rd_data !== 8'h60) $display("FAIL single_rd_hold: got %h expected 60", rd_data); else passed++;
    endtask

    task automatic test_round_robin();
        logic exp_cpu, exp_dbg;
        rst      = 1'b1;
        cpu_addr = 8'h00;
        dbg_addr = 8'h09;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        tick();
        rst = 1'b0;
        for (int t = 1; t <= 11; t++) begin
            tick();
            exp_cpu = (t % 3 == 2) && ((t / 3) % 2 == 0);
            exp_dbg = (t % 3 == 2) && ((t / 3) % 2 == 1);
            total++;
            if (cpu_ack !== exp_cpu || dbg_ack !== exp_dbg)
                $display("FAIL rr_acks t=%0d: got cpu=%b dbg=%b expected cpu=%b dbg=%b", t, cpu_ack, dbg_ack, exp_cpu, exp_dbg);
            else passed++;
            if (exp_cpu || exp_dbg) begin
                total++;
                if (rd_data !== (exp_cpu ? 8'h01 : 8'h53))
                    $display("FAIL rr_rd_data t=%0d: got %h expected %h", t, rd_data, exp_cpu ? 8'h01 : 8'h53);
                else passed++;
            end
        end
        tick();
        idle_out();
    endtask

    task automatic test_lock();
        logic exp_dbg;
        cpu_addr = 8'h02;
        dbg_addr = 8'h09;
        dbg_lock = 1'b1;
        cpu_req  = 1'b1;
        dbg_req  = 1'b1;
        for (int t = 1; t <= 9; t++) begin
            tick();
            exp_dbg = (t % 3 == 2);
            total++;
            if (cpu_ack !== 1'b0 || dbg_ack !== exp_dbg)
                $display("FAIL lock_acks t=%0d: got cpu=%b dbg=%b expected cpu=0 dbg=%b", t, cpu_ack, dbg_ack, exp_dbg);
            else passed++;
        end
        dbg_lock = 1'b0;
        tick();
        tick();
        total++; if (cpu_ack !== 1'b1 || dbg_ack !== 1'b0) $display("FAIL unlock_tie: got cpu=%b dbg=%b expected cpu=1 dbg=0", cpu_ack, dbg_ack); else passed++;
        total++; if (rd_data !== 8'h60) $display("FAIL unlock_rd_data: got %h expected 60", rd_data); else passed++;
        idle_out();
    endtask

    task automatic test_reset_abort();
        cpu_addr = 8'h02;
        cpu_req  = 1'b1;
        tick();
        total++; if (busy !== 1'b1) $display("FAIL abort_in_read: got busy=%b expected 1", busy); else passed++;
        rst = 1'b1;
        tick();
        total++; if (cpu_ack !== 1'b0) $display("FAIL abort_no_ack: got %b expected 0", cpu_ack); else passed++;
        total++; if (busy !== 1'b0 || rd_data !== 8'h00) $display("FAIL abort_cleared: got busy=%b rd=%h expected 0 00", busy, rd_data); else passed++;
        rst = 1'b0;
        tick();
        total++; if (cpu_ack !== 1'b0 || busy !== 1'b1) $display("FAIL abort_rearb: got ack=%b busy=%b expected 0 1", cpu_ack, busy); else passed++;
        tick();
        total++; if (cpu_ack !== 1'b1 || rd_data !== 8'h60) $display("FAIL abort_reack: got ack=%b rd=%h expected 1 60", cpu_ack, rd_data); else passed++;
        idle_out();
    endtask

    task automatic test_drop();
        cpu_addr = 8'hFF;
        cpu_req  = 1'b1;
        tick();
        cpu_req = 1'b0;
        total++; if (rom_address !== 8'hFF) $display("FAIL drop_rom_address: got %h expected ff", rom_address); else passed++;
        tick();
        total++; if (cpu_ack !== 1'b1 || rd_data !== 8'hA5) $display("FAIL drop_ack: got ack=%b rd=%h expected 1 a5", cpu_ack, rd_data); else passed++;
        for (int t = 3; t <= 6; t++) begin
            tick();
            total++;
            if (cpu_ack !== 1'b0 || busy !== 1'b0)
                $display("FAIL drop_quiet t=%0d: got ack=%b busy=%b expected 0 0", t, cpu_ack, busy);
            else passed++;
        end
    endtask

    initial begin
        for (int i = 0; i < 256; i++) rom[i] = 8'(i) ^ 8'h5A;
        rom[0] = 8'h01;
        rom[2] = 8'h60;
        rst = 1'b1; cpu_req = 1'b0; dbg_req = 1'b0; dbg_lock = 1'b0;
        cpu_addr = 8'h00; dbg_addr = 8'h00;
        test_reset();
        test_single();
        test_round_robin();
        test_lock();
        test_reset_abort();
        test_drop();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
